// File: rtl/fpu_adder_if.sv
// Operand/result bundle for the binary32 adder. The flags field exists only when
// FPU_FLAGS_EN is defined; F3 behaves the same in both builds.
interface fpu_adder_if;
  logic [31:0] F1;
  logic [31:0] F2;
  logic [31:0] F3;
`ifdef FPU_FLAGS_EN
  logic [4:0]  flags;
  modport master (output F1, output F2, input F3, input flags);
  modport slave  (input F1, input F2, output F3, output flags);
`else
  modport master (output F1, output F2, input F3);
  modport slave  (input F1, input F2, output F3);
`endif
endinterface

// File: rtl/fpu_adder.sv
// Single-precision IEEE-754 adder, round-to-nearest-even, one-cycle registered result.
// Optional FPU_FLAGS_EN adds a registered {invalid, overflow, underflow, inexact, zero} port.
module fpu_adder (
  input  logic       clk,
  input  logic       rst_n,
  fpu_adder_if.slave bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // No handshake: F1/F2 are sampled on every rising edge and F3 is valid one edge later.

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic        w_special;

  assign w_sa     = bus.F1[31];
  assign w_sb     = bus.F2[31];
  assign w_ea     = bus.F1[30:23];
  assign w_eb     = bus.F2[30:23];
  assign w_fa     = bus.F1[22:0];
  assign w_fb     = bus.F2[22:0];
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

  logic        w_a_big;
  logic        w_sbig;
  logic [7:0]  w_ebig, w_esml, w_diff;
  logic [23:0] w_sig_big, w_sig_sml;
  logic [49:0] w_ext;
  logic        w_sticky;
  logic [26:0] w_op_big, w_op_sml;
  logic [27:0] w_sum;

  assign w_a_big   = {w_ea, w_fa} >= {w_eb, w_fb};
  assign w_sbig    = w_a_big ? w_sa : w_sb;
  assign w_ebig    = w_a_big ? w_ea : w_eb;
  assign w_esml    = w_a_big ? w_eb : w_ea;
  assign w_sig_big = {1'b1, (w_a_big ? w_fa : w_fb)};
  assign w_sig_sml = {1'b1, (w_a_big ? w_fb : w_fa)};
  assign w_diff    = w_ebig - w_esml;

  // Smaller significand sits above 26 zero bits; after the shift [49:24] holds sig+guard+round
  // and everything below collapses into sticky. Shifts of 26+ leave only sticky set.
  assign w_ext     = (w_diff < 8'd26) ? ({w_sig_sml, 26'd0} >> w_diff) : 50'd0;
  assign w_sticky  = (w_diff >= 8'd26) | (|w_ext[23:0]);
  assign w_op_big  = {w_sig_big, 3'b000};
  assign w_op_sml  = {w_ext[49:24], w_sticky};
  assign w_sum     = (w_sa == w_sb) ? ({1'b0, w_op_big} + {1'b0, w_op_sml})
                                    : ({1'b0, w_op_big} - {1'b0, w_op_sml});

  logic [4:0]        w_lz;
  logic [26:0]       w_norm;
  logic              w_rup;
  logic [24:0]       w_rnd;
  logic signed [9:0] w_e_pre, w_e_fin;
  logic [22:0]       w_frac;
  logic              w_nonzero;
  logic              w_ovf, w_unf;

  assign w_lz      = lzc27(w_sum[26:0]);
  // Carry-out folds the dropped bit into sticky; otherwise left-justify on the leading one.
  assign w_norm    = w_sum[27] ? {w_sum[27:2], |w_sum[1:0]} : (w_sum[26:0] << w_lz);
  assign w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_rnd     = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
  assign w_e_pre   = w_sum[27] ? ($signed({2'b00, w_ebig}) + 10'sd1)
                               : ($signed({2'b00, w_ebig}) - $signed({5'd0, w_lz}));
  assign w_e_fin   = w_e_pre + $signed({9'd0, w_rnd[24]});
  assign w_frac    = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
  assign w_nonzero = (w_sum != 28'd0);
  assign w_ovf     = !w_special && w_nonzero && (w_e_fin >= 10'sd255);
  assign w_unf     = !w_special && w_nonzero && (w_e_fin <= 10'sd0);

  logic [31:0] w_res;

  always_comb begin
    w_res = {w_sbig, w_e_fin[7:0], w_frac};
    if (w_a_nan || w_b_nan) begin
      w_res = QNAN;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_res = QNAN;
    end else if (w_a_inf) begin
      w_res = bus.F1;
    end else if (w_b_inf) begin
      w_res = bus.F2;
    end else if (w_a_zero && w_b_zero) begin
      w_res = {w_sa & w_sb, 31'd0};
    end else if (w_a_zero) begin
      w_res = bus.F2;
    end else if (w_b_zero) begin
      w_res = bus.F1;
    end else if (!w_nonzero) begin
      w_res = 32'h0000_0000;
    end else if (w_ovf) begin
      w_res = {w_sbig, 8'hFF, 23'd0};
    end else if (w_unf) begin
      w_res = {w_sbig, 31'd0};
    end
  end

  logic [31:0] r_f3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3 <= 32'd0;
    end else begin
      r_f3 <= w_res;
    end
  end

  assign bus.F3 = r_f3;

`ifdef FPU_FLAGS_EN
  logic       w_inv, w_inx;
  logic [4:0] w_flags;
  logic [4:0] r_flags;

  assign w_inv   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
  assign w_inx   = w_ovf | w_unf | (!w_special && w_nonzero && (|w_norm[2:0]));
  assign w_flags = {w_inv, w_ovf, w_unf, w_inx, (w_res[30:0] == 31'd0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 5'd0;
    end else begin
      r_flags <= w_flags;
    end
  end

  assign bus.flags = r_flags;
`endif

endmodule

// File: tb/tb_fpu_adder.sv
// Bench for fpu_adder: directed vectors plus random pairs scored against a real-arithmetic model.
// Flag checks are compiled in only when FPU_FLAGS_EN is defined.
module tb_fpu_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_adder_if bus();

  fpu_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  expf_q[$];

  // ---------------- reference model ----------------
  function automatic real to_real(input logic [31:0] f);
    logic [10:0] e;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  // Returns {flags, result}; flags = {invalid, overflow, underflow, inexact, zero}.
  function automatic logic [36:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_z, b_z;
    real ra, rb, s, err, abs_a, abs_b;
    logic [63:0] bits;
    logic [28:0] rem;
    logic [24:0] keep;
    logic up, inx;
    int e;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_z   = (a[30:23] == 8'h00);
    b_z   = (b[30:23] == 8'h00);
    if (a_nan || b_nan) return {5'b10000, 32'h7FC00000};
    if (a_inf && b_inf && (a[31] != b[31])) return {5'b10000, 32'h7FC00000};
    if (a_inf) return {5'b00000, a};
    if (b_inf) return {5'b00000, b};
    if (a_z && b_z) return {5'b00001, a[31] & b[31], 31'd0};
    if (a_z) return {5'b00000, b};
    if (b_z) return {5'b00000, a};
    ra = to_real(a);
    rb = to_real(b);
    s  = ra + rb;
    abs_a = (ra < 0.0) ? -ra : ra;
    abs_b = (rb < 0.0) ? -rb : rb;
    err = (abs_a >= abs_b) ? (rb - (s - ra)) : (ra - (s - rb));
    if (s == 0.0) return {5'b00001, 32'h00000000};
    bits = $realtobits(s);
    rem  = bits[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && bits[29]);
    keep = {2'b01, bits[51:29]} + {24'd0, up};
    e    = int'(bits[62:52]) - 896;
    if (keep[24]) e = e + 1;
    inx  = (rem != 0) || (err != 0.0);
    if (e >= 255) return {5'b01010, bits[63], 8'hFF, 23'd0};
    if (e <= 0)   return {5'b00111, bits[63], 31'd0};
    return {3'b000, inx, 1'b0, bits[63], 8'(e), (keep[24] ? keep[23:1] : keep[22:0])};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.F1 = a;
    bus.F2 = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic s, input int e, input logic [22:0] f);
    return {s, 8'(e), f};
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    logic [31:0] sp[7];
    logic [31:0] t;
    int ea, eb;
    logic s;
    sp = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFFC00001,
           32'h00000000, 32'h80000000, 32'h00012345};
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: begin a = $urandom; b = $urandom; end
      1: begin
        a = sp[$urandom_range(0, 6)];
        b = mk(s, int'($urandom_range(1, 254)), 23'($urandom));
        if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
      end
      2: begin
        ea = int'($urandom_range(2, 253));
        a  = mk(s, ea, 23'($urandom));
        b  = mk(~s, ea + int'($urandom_range(0, 2)) - 1, a[22:0] ^ 23'($urandom_range(0, 255)));
      end
      3: begin
        a = mk(s, int'($urandom_range(250, 254)), 23'($urandom));
        b = mk(1'($urandom_range(0, 1)), int'($urandom_range(250, 254)), 23'($urandom));
      end
      4: begin
        a = mk(s, int'($urandom_range(1, 3)), 23'($urandom));
        b = mk(~s, int'($urandom_range(1, 3)), 23'($urandom));
      end
      default: begin
        ea = int'($urandom_range(1, 254));
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        a = mk(s, ea, 23'($urandom));
        b = mk(1'($urandom_range(0, 1)), eb, 23'($urandom));
      end
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.F1 = 32'h3F800000;
    bus.F2 = 32'h3F800000;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.F3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 00000000", bus.F3);
    end
`ifdef FPU_FLAGS_EN
    n_tests++;
    if (bus.flags !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", bus.flags);
    end
`endif
    @(negedge clk);
    bus.F1 = 32'h0;
    bus.F2 = 32'h0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.F3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 00000000", bus.F3);
    end
    drive(32'h3F800000, 32'h3F800000);
    n_tests++;
    if (bus.F3 !== 32'h40000000) begin
      n_fail++;
      $display("FAIL first_op: got %h expected 40000000", bus.F3);
    end
    // Mid-stream reset: clears asynchronously and discards the pending pair.
    @(negedge clk);
    bus.F1 = 32'h40000000;
    bus.F2 = 32'h40000000;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.F3 !== 32'h0) begin
      n_fail++;
      $display("FAIL async_clear: got %h expected 00000000", bus.F3);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.F3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_discard: got %h expected 00000000", bus.F3);
    end
    @(negedge clk);
    bus.F1 = 32'h3F800000;
    bus.F2 = 32'h40000000;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.F3 !== 32'h40400000) begin
      n_fail++;
      $display("FAIL first_edge_capture: got %h expected 40400000", bus.F3);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[17];
    logic [31:0] vb[17];
    logic [31:0] vr[17];
    va = '{32'h3F400000, 32'h3D99999A, 32'hBF000000, 32'h3F000000, 32'hBF000000,
           32'h3F800000, 32'h3F7FFFFF, 32'h3FFFFFFF, 32'h7F800000, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'h7F800000, 32'h00000000, 32'hFF7FFFFF, 32'h80000000,
           32'h80000000, 32'h00000000};
    vb = '{32'h3EE00000, 32'h3BF5C28F, 32'h3BEE0000, 32'hBEE00000, 32'h3EE00000,
           32'hBF800000, 32'h3F000000, 32'h40000000, 32'h7F000000, 32'h3FC51EB8,
           32'h7F800000, 32'hFF800000, 32'h40A00000, 32'h3FC51EB8, 32'h80000000,
           32'h00000000, 32'h80000000};
    vr = '{32'h3F980000, 32'h3DA8F5C3, 32'hBEFC4800, 32'h3D800000, 32'hBD800000,
           32'h00000000, 32'h3FC00000, 32'h40800000, 32'h7F800000, 32'h7FC00000,
           32'h7FC00000, 32'h7FC00000, 32'h40A00000, 32'hFF7FFFFF, 32'h80000000,
           32'h00000000, 32'h00000000};
    for (int i = 0; i < 17; i++) begin
      drive(va[i], vb[i]);
      n_tests++;
      if (bus.F3 !== vr[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: %h+%h got %h expected %h", i, va[i], vb[i], bus.F3, vr[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va[2];
    logic [31:0] vr[2];
    va = '{32'h7F000003, 32'hFF000003};
    vr = '{32'h7F800000, 32'hFF800000};
    for (int i = 0; i < 2; i++) begin
      drive(va[i], va[i]);
      n_tests++;
      if (bus.F3 !== vr[i]) begin
        n_fail++;
        $display("FAIL overflow_%0d: got %h expected %h", i, bus.F3, vr[i]);
      end
`ifdef FPU_FLAGS_EN
      n_tests++;
      if (bus.flags !== 5'b01010) begin
        n_fail++;
        $display("FAIL overflow_flags_%0d: got %b expected 01010", i, bus.flags);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [36:0] m;
    logic [31:0] er;
    logic [4:0]  ef;
    for (int i = 0; i < 600; i++) begin
      gen_pair(a, b);
      m = ref_add(a, b);
      exp_q.push_back(m[31:0]);
      expf_q.push_back(m[36:32]);
      drive(a, b);
      er = exp_q.pop_front();
      ef = expf_q.pop_front();
      n_tests++;
      if (bus.F3 !== er) begin
        n_fail++;
        $display("FAIL random_%0d: %h+%h got %h expected %h", i, a, b, bus.F3, er);
      end
`ifdef FPU_FLAGS_EN
      n_tests++;
      if (bus.flags !== ef) begin
        n_fail++;
        $display("FAIL random_flags_%0d: %h+%h got %b expected %b", i, a, b, bus.flags, ef);
      end
`else
      if (ef === 5'bxxxxx) $display("unexpected unknown flags");
`endif
    end
  endtask

  initial begin
    bus.F1 = 32'h0;
    bus.F2 = 32'h0;
    test_reset();
    test_directed();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
